// File: rtl/mem_port_arbiter.sv
// Shares one req/gnt/rvalid memory port between instruction fetch and load/store.
// Pulses are held as pending until won; a watchdog ends any access the bus never answers.
module mem_port_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255,
  parameter int TO_W    = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic                if_done,
  output logic                if_err,
  output logic [DATA_W-1:0]   if_rdata,
  input  logic                ls_req,
  input  logic                ls_we,
  input  logic [ADDR_W-1:0]   ls_addr,
  input  logic [DATA_W-1:0]   ls_wdata,
  input  logic [DATA_W/8-1:0] ls_be,
  output logic                ls_done,
  output logic                ls_err,
  output logic [DATA_W-1:0]   ls_rdata,
  output logic                m_req,
  output logic                m_we,
  output logic [ADDR_W-1:0]   m_addr,
  output logic [DATA_W-1:0]   m_wdata,
  output logic [DATA_W/8-1:0] m_be,
  input  logic                m_gnt,
  input  logic                m_rvalid,
  input  logic [DATA_W-1:0]   m_rdata,
  output logic                busy
);
  localparam int BE_W = DATA_W / 8;

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_REQ = 2'd1, S_WAIT = 2'd2} state_t;

  state_t            r_state, w_next;
  logic              r_pend_if, r_pend_ls, r_owner_ls, r_last_ls;
  logic [TO_W-1:0]   r_wd;
  logic [ADDR_W-1:0] r_if_addr, r_ls_addr;
  logic              r_ls_we;
  logic [DATA_W-1:0] r_ls_wdata;
  logic [BE_W-1:0]   r_ls_be;
  logic              r_m_req, r_m_we;
  logic [ADDR_W-1:0] r_m_addr;
  logic [DATA_W-1:0] r_m_wdata;
  logic [BE_W-1:0]   r_m_be;
  logic              r_if_done, r_if_err, r_ls_done, r_ls_err;
  logic [DATA_W-1:0] r_if_rdata, r_ls_rdata;

  logic              w_active, w_cand_if, w_cand_ls, w_win_ls, w_accept;
  logic              w_if_take, w_ls_take, w_complete, w_abort, w_finish;
  logic [TO_W-1:0]   w_wd_inc;
  logic [ADDR_W-1:0] w_if_addr, w_ls_addr;
  logic              w_ls_we;
  logic [DATA_W-1:0] w_ls_wdata;
  logic [BE_W-1:0]   w_ls_be;

  assign w_active  = (r_state != S_IDLE);
  assign w_cand_if = r_pend_if | if_req;
  assign w_cand_ls = r_pend_ls | ls_req;
  // Round-robin only matters on a tie: LS normally wins, IF if LS had the last turn.
  assign w_win_ls  = w_cand_ls & (~w_cand_if | ~r_last_ls);
  assign w_accept  = (r_state == S_IDLE) & (w_cand_if | w_cand_ls);

  // A pulse from a requester that is already pending or owns the port is dropped.
  assign w_if_take = if_req & ~r_pend_if & ~(w_active & ~r_owner_ls);
  assign w_ls_take = ls_req & ~r_pend_ls & ~(w_active &  r_owner_ls);

  // Fields arrive only with the pulse, so a pending request uses its captured copy.
  assign w_if_addr  = r_pend_if ? r_if_addr  : if_addr;
  assign w_ls_addr  = r_pend_ls ? r_ls_addr  : ls_addr;
  assign w_ls_we    = r_pend_ls ? r_ls_we    : ls_we;
  assign w_ls_wdata = r_pend_ls ? r_ls_wdata : ls_wdata;
  assign w_ls_be    = r_pend_ls ? r_ls_be    : ls_be;

  assign w_wd_inc   = r_wd + TO_W'(1);
  assign w_complete = (r_state == S_WAIT) & m_rvalid;
  assign w_abort    = w_active & (w_wd_inc == TO_W'(TIMEOUT)) & ~w_complete;
  assign w_finish   = w_complete | w_abort;

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_next = S_REQ;
      S_REQ:   if (w_abort) w_next = S_IDLE;
               else if (m_gnt) w_next = S_WAIT;
      S_WAIT:  if (w_finish) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pend_if  <= 1'b0;
      r_pend_ls  <= 1'b0;
      r_owner_ls <= 1'b0;
      r_last_ls  <= 1'b0;
      r_wd       <= '0;
      r_if_addr  <= '0;
      r_ls_addr  <= '0;
      r_ls_we    <= 1'b0;
      r_ls_wdata <= '0;
      r_ls_be    <= '0;
      r_m_req    <= 1'b0;
      r_m_we     <= 1'b0;
      r_m_addr   <= '0;
      r_m_wdata  <= '0;
      r_m_be     <= '0;
      r_if_done  <= 1'b0;
      r_if_err   <= 1'b0;
      r_ls_done  <= 1'b0;
      r_ls_err   <= 1'b0;
      r_if_rdata <= '0;
      r_ls_rdata <= '0;
    end else begin
      r_pend_if <= (r_pend_if | w_if_take) & ~(w_accept & ~w_win_ls);
      r_pend_ls <= (r_pend_ls | w_ls_take) & ~(w_accept &  w_win_ls);
      if (w_if_take) r_if_addr <= if_addr;
      if (w_ls_take) begin
        r_ls_addr  <= ls_addr;
        r_ls_we    <= ls_we;
        r_ls_wdata <= ls_wdata;
        r_ls_be    <= ls_be;
      end

      r_m_req <= (w_next == S_REQ);
      if (w_accept) begin
        r_owner_ls <= w_win_ls;
        r_last_ls  <= w_win_ls;
        r_wd       <= '0;
        if (w_win_ls) begin
          r_m_we    <= w_ls_we;
          r_m_addr  <= w_ls_addr;
          r_m_wdata <= w_ls_wdata;
          r_m_be    <= w_ls_be;
        end else begin
          r_m_we    <= 1'b0;
          r_m_addr  <= w_if_addr;
          r_m_wdata <= '0;
          r_m_be    <= '1;
        end
      end else if (w_active) begin
        r_wd <= w_wd_inc;
      end

      r_if_done <= w_finish & ~r_owner_ls;
      r_if_err  <= w_abort  & ~r_owner_ls;
      r_ls_done <= w_finish &  r_owner_ls;
      r_ls_err  <= w_abort  &  r_owner_ls;
      if (w_finish & ~r_owner_ls) r_if_rdata <= w_complete ? m_rdata : '0;
      if (w_finish &  r_owner_ls) r_ls_rdata <= (w_complete & ~r_m_we) ? m_rdata : '0;
    end
  end

  assign if_done  = r_if_done;
  assign if_err   = r_if_err;
  assign if_rdata = r_if_rdata;
  assign ls_done  = r_ls_done;
  assign ls_err   = r_ls_err;
  assign ls_rdata = r_ls_rdata;
  assign m_req    = r_m_req;
  assign m_we     = r_m_we;
  assign m_addr   = r_m_addr;
  assign m_wdata  = r_m_wdata;
  assign m_be     = r_m_be;
  // An arriving pulse counts as busy so the hold never dips on a back-to-back access.
  assign busy     = w_active | w_cand_if | w_cand_ls;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios then random traffic, checked against
// a transaction-level model of arbitration order, bus timing and watchdog outcome.
module tb_mem_port_arbiter;
  localparam int AW = 32, DW = 32, BW = DW / 8, TO = 4;

  logic          clk = 1'b0, rst = 1'b1;
  logic          if_req = 1'b0, ls_req = 1'b0, ls_we = 1'b0;
  logic [AW-1:0] if_addr = '0, ls_addr = '0;
  logic [DW-1:0] ls_wdata = '0, m_rdata = '0;
  logic [BW-1:0] ls_be = '0;
  logic          m_gnt = 1'b0, m_rvalid = 1'b0;
  logic          if_done, if_err, ls_done, ls_err, m_req, m_we, busy;
  logic [DW-1:0] if_rdata, ls_rdata, m_wdata;
  logic [AW-1:0] m_addr;
  logic [BW-1:0] m_be;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO), .TO_W(3)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_done(if_done), .if_err(if_err), .if_rdata(if_rdata),
    .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr), .ls_wdata(ls_wdata), .ls_be(ls_be),
    .ls_done(ls_done), .ls_err(ls_err), .ls_rdata(ls_rdata),
    .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata), .m_be(m_be),
    .m_gnt(m_gnt), .m_rvalid(m_rvalid), .m_rdata(m_rdata), .busy(busy)
  );

  int n_cmp = 0, n_bad = 0, cyc = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s @%0d: got %0h want %0h", tag, cyc, got, exp);
    end
  endtask

  // Model: per requester 0=IF 1=LS, st 0=none 1=waiting 2=on the bus.
  int            st [2];
  logic [AW-1:0] q_addr [2];
  logic [DW-1:0] q_wdata [2];
  logic          q_we [2];
  logic [BW-1:0] q_be [2];
  logic [DW-1:0] exp_rd [2];
  bit            last_ls;
  bit            tr_act, tr_err;
  int            tr_own, tr_E, tr_gnt, tr_rv, tr_done;
  logic [DW-1:0] tr_data;
  // Directed knobs
  bit            rnd_on, rv_spam, f_data_on;
  bit            want [2];
  int            f_d1, f_d2;
  logic [DW-1:0] f_data, f_wdata;
  logic [AW-1:0] f_addr [2];
  logic          f_we;
  logic [BW-1:0] f_be;

  task automatic step();
    bit ed [2];
    bit eb;
    int d1, d2, w;
    @(negedge clk);
    ed[0] = 1'b0; ed[1] = 1'b0;
    if (tr_act && cyc == tr_done) begin
      ed[tr_own] = 1'b1;
      exp_rd[tr_own] = (tr_err || (tr_own == 1 && q_we[1])) ? '0 : tr_data;
    end
    chk("if_done", 64'(if_done), 64'(ed[0]));
    chk("ls_done", 64'(ls_done), 64'(ed[1]));
    chk("if_err", 64'(if_err), 64'(ed[0] & tr_err));
    chk("ls_err", 64'(ls_err), 64'(ed[1] & tr_err));
    chk("if_rdata", 64'(if_rdata), 64'(exp_rd[0]));
    chk("ls_rdata", 64'(ls_rdata), 64'(exp_rd[1]));
    if (tr_act && cyc < tr_done) begin
      chk("m_req", 64'(m_req), 64'(cyc <= tr_gnt && cyc < tr_E + TO));
      chk("m_addr", 64'(m_addr), 64'(q_addr[tr_own]));
      chk("m_we", 64'(m_we), 64'(tr_own == 1 ? q_we[1] : 1'b0));
      chk("m_be", 64'(m_be), 64'(tr_own == 1 ? q_be[1] : {BW{1'b1}}));
      if (tr_own == 1) chk("m_wdata", 64'(m_wdata), 64'(q_wdata[1]));
    end else begin
      chk("m_req_idle", 64'(m_req), 64'(0));
    end
    if (tr_act && cyc == tr_done) begin
      st[tr_own] = 0;
      tr_act = 1'b0;
    end

    // Memory side: junk gnt/rvalid wherever the arbiter must ignore them.
    m_gnt    = ($urandom_range(3) == 0);
    m_rvalid = ($urandom_range(3) == 0) || (rv_spam && !tr_act);
    m_rdata  = $urandom;
    if (tr_act) begin
      if (cyc <= tr_gnt) m_gnt = (cyc == tr_gnt);
      else begin
        m_rvalid = (cyc == tr_rv) && !tr_err;
        if (m_rvalid) m_rdata = tr_data;
      end
    end

    // Requests; fields carry garbage except in the pulse cycle.
    if_req = 1'b0; ls_req = 1'b0;
    if_addr = $urandom; ls_addr = $urandom; ls_wdata = $urandom;
    ls_we = 1'($urandom_range(1)); ls_be = BW'($urandom);
    for (int r = 0; r < 2; r++) begin
      if (st[r] == 0 && (want[r] || (rnd_on && $urandom_range(2) == 0))) begin
        st[r] = 1;
        if (want[r]) begin
          q_addr[r] = f_addr[r]; q_we[r] = f_we; q_wdata[r] = f_wdata; q_be[r] = f_be;
        end else begin
          q_addr[r] = $urandom; q_we[r] = 1'($urandom_range(1));
          q_wdata[r] = $urandom; q_be[r] = BW'($urandom);
        end
        want[r] = 1'b0;
        if (r == 0) begin
          if_req = 1'b1; if_addr = q_addr[0];
        end else begin
          ls_req = 1'b1; ls_addr = q_addr[1]; ls_we = q_we[1];
          ls_wdata = q_wdata[1]; ls_be = q_be[1];
        end
      end
    end
    eb = tr_act || st[0] == 1 || st[1] == 1;

    if (!tr_act && (st[0] == 1 || st[1] == 1)) begin
      w = (st[1] == 1 && (st[0] != 1 || !last_ls)) ? 1 : 0;
      last_ls = (w == 1);
      st[w] = 2; tr_own = w; tr_E = cyc + 1;
      d1 = (f_d1 >= 0) ? f_d1 : int'($urandom_range(3));
      d2 = (f_d2 >= 0) ? f_d2 : int'($urandom_range(3));
      tr_gnt = tr_E + d1;
      tr_rv  = tr_gnt + 1 + d2;
      tr_err = (d1 + d2 + 2 > TO);
      tr_done = tr_err ? tr_E + TO : tr_rv + 1;
      tr_data = f_data_on ? f_data : $urandom;
      tr_act = 1'b1;
    end
    #1;
    chk("busy", 64'(busy), 64'(eb));
    cyc++;
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  initial begin
    bit b2b;
    st[0] = 0; st[1] = 0; exp_rd[0] = '0; exp_rd[1] = '0;
    want[0] = 1'b0; want[1] = 1'b0;
    last_ls = 1'b0; tr_act = 1'b0; tr_err = 1'b0; rnd_on = 1'b0; rv_spam = 1'b0;
    f_d1 = 0; f_d2 = 0; f_data_on = 1'b0; f_data = '0;
    f_addr[0] = '0; f_addr[1] = '0; f_we = 1'b0; f_wdata = '0; f_be = '1;

    repeat (3) @(negedge clk);
    chk("rst_if_done", 64'(if_done), 64'(0));
    chk("rst_ls_done", 64'(ls_done), 64'(0));
    chk("rst_m_req", 64'(m_req), 64'(0));
    chk("rst_m_addr", 64'(m_addr), 64'(0));
    chk("rst_m_be", 64'(m_be), 64'(0));
    chk("rst_rdata", 64'({if_rdata, ls_rdata}), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    rst = 1'b0;

    // Single fetch, minimum latency.
    f_addr[0] = 32'h100; f_data_on = 1'b1; f_data = 32'h00500093; want[0] = 1'b1;
    run(6);
    chk("fetch_rdata", 64'(if_rdata), 64'h00500093);
    f_data_on = 1'b0;

    // Collision with last_ls=0: LS first, then IF.
    f_addr[0] = 32'h200; f_addr[1] = 32'h3000; f_we = 1'b0; f_be = 4'hF;
    want[0] = 1'b1; want[1] = 1'b1;
    run(10);

    // Store, then a collision after an LS turn: IF first.
    f_addr[1] = 32'h2004; f_we = 1'b1; f_wdata = 32'hDEADBEEF; f_be = 4'b0011; want[1] = 1'b1;
    run(6);
    chk("store_rdata", 64'(ls_rdata), 64'(0));
    f_addr[0] = 32'h204; f_addr[1] = 32'h3008; f_we = 1'b0; f_be = 4'b1100;
    want[0] = 1'b1; want[1] = 1'b1;
    run(10);

    // Timeout: granted, never answered; rvalid then spammed while idle.
    f_d1 = 0; f_d2 = 9; rv_spam = 1'b1; f_addr[1] = 32'h4000; want[1] = 1'b1;
    run(10);
    rv_spam = 1'b0; f_d2 = 0;

    // Back-to-back: LS pulse in the if_done cycle.
    f_addr[0] = 32'h300; f_addr[1] = 32'h5000; f_we = 1'b1; f_wdata = 32'h12345678; f_be = 4'hF;
    want[0] = 1'b1; b2b = 1'b0;
    for (int i = 0; i < 12 && !b2b; i++) begin
      if (tr_act && tr_own == 0 && cyc == tr_done) begin
        want[1] = 1'b1; b2b = 1'b1;
      end
      step();
    end
    chk("b2b_reached", 64'(b2b), 64'(1));
    run(6);

    // Random traffic with random bus delays, including timeouts.
    f_d1 = -1; f_d2 = -1; rnd_on = 1'b1;
    run(1500);
    rnd_on = 1'b0;
    run(20);

    // Reset with m_req in flight.
    f_d1 = 2; f_d2 = 0; f_addr[0] = 32'h40; want[0] = 1'b1;
    run(2);
    chk("pre_rst_m_req", 64'(m_req), 64'(1));
    rst = 1'b1; if_req = 1'b0; ls_req = 1'b0; m_gnt = 1'b0; m_rvalid = 1'b0;
    @(negedge clk); #1;
    chk("mid_rst_m_req", 64'(m_req), 64'(0));
    chk("mid_rst_busy", 64'(busy), 64'(0));
    chk("mid_rst_done", 64'({if_done, ls_done}), 64'(0));
    rst = 1'b0;
    @(negedge clk); #1;
    chk("post_rst_done", 64'({if_done, ls_done}), 64'(0));
    chk("post_rst_m_req", 64'(m_req), 64'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
